// File: rtl/spi_pkg.sv
// Shared SPI types and constants for the master transmitter and the target receiver.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_DONE} tx_state_t;

  localparam logic [4:0] SPI_W8  = 5'd8;
  localparam logic [4:0] SPI_W16 = 5'd16;

  function automatic logic [4:0] frame_bits(input logic w8);
    return w8 ? SPI_W8 : SPI_W16;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser with one extra history flop for single-clk rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{rst_val}};
      prev <= rst_val;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_rx.sv
// SPI target receiver: oversampled SS_n/SCLK/MOSI, MSB-first 8/16-bit words on a valid/ready port.
// Optional reply shifter on MISO when SPI_RX_MISO_EN is defined.
module spi_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        pos_edge,
  input  logic        width8,
  input  logic        rx_rdy,
  input  logic        clr_err,
`ifdef SPI_RX_MISO_EN
  input  logic [15:0] tx_reply,
  output logic        MISO,
  output logic        reply_taken,
`endif
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        overrun,
  output logic        frame_err,
  output logic        busy
);

  logic ss_q, ss_fall, ss_rise_unused;
  logic sclk_q_unused, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_d;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .rst_n(rst_n), .rst_val(1'b1), .d(SS_n),
    .q(ss_q), .rise(ss_rise_unused), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst_n(rst_n), .rst_val(~pos_edge), .d(SCLK),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // MOSI travels the same depth as SCLK so a sample sees data as of the SCLK edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_d <= '0;
    else        mosi_d <= {mosi_d[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_d[SYNC_STAGES-1];

  rx_state_t   state, state_nx;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic        pe_l, w8_l;
  logic        smp_edge;
  logic        clr, shift_en, done_set, ferr_set, done;

  assign smp_edge = pe_l ? sclk_rise : sclk_fall;
  assign busy     = ~ss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    shift_en = 1'b0;
    done_set = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nx = SHIFT;
          clr      = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_q) begin
          state_nx = IDLE;
          ferr_set = (bit_cnt != 5'd0);
        end else if (smp_edge) begin
          shift_en = 1'b1;
          if (bit_cnt + 5'd1 == frame_bits(w8_l)) begin
            state_nx = WAIT_END;
            done_set = 1'b1;
          end
        end
      end
      WAIT_END: begin
        if (ss_q) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Mode bits are frozen at frame start so mid-frame changes cannot corrupt the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 5'd0;
      shift_reg <= 16'h0000;
      pe_l      <= 1'b1;
      w8_l      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= done_set;
      frame_err <= ferr_set;
      if (clr) begin
        bit_cnt   <= 5'd0;
        shift_reg <= 16'h0000;
        pe_l      <= pos_edge;
        w8_l      <= width8;
      end else if (shift_en) begin
        bit_cnt   <= bit_cnt + 5'd1;
        shift_reg <= {shift_reg[14:0], mosi_s};
      end
    end
  end

  // A completing word may load in the same clk the previous one is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= 16'h0000;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (done && (!rx_valid || rx_rdy)) begin
        rx_data  <= w8_l ? {8'h00, shift_reg[7:0]} : shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_rdy) begin
        rx_valid <= 1'b0;
      end
      if (done && rx_valid && !rx_rdy) overrun <= 1'b1;
      else if (clr_err)                overrun <= 1'b0;
    end
  end

`ifdef SPI_RX_MISO_EN
  logic [15:0] reply_reg;
  logic        nsmp_edge;

  assign nsmp_edge = pe_l ? sclk_fall : sclk_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            reply_reg <= 16'h0000;
    else if (clr)                          reply_reg <= tx_reply;
    else if (state == SHIFT && nsmp_edge)  reply_reg <= {reply_reg[14:0], 1'b0};
  end

  assign MISO        = ss_q ? 1'b0 : reply_reg[15];
  assign reply_taken = done;
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: bit-banged SPI master model, hand-computed words, one summary line.
module tb_spi_rx;

  logic        clk, rst_n, SS_n, SCLK, MOSI, pos_edge, width8, rx_rdy, clr_err;
  logic [15:0] rx_data;
  logic        rx_valid, overrun, frame_err, busy;
`ifdef SPI_RX_MISO_EN
  logic [15:0] tx_reply;
  logic        MISO, reply_taken;
`endif

  spi_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .pos_edge(pos_edge), .width8(width8), .rx_rdy(rx_rdy), .clr_err(clr_err),
`ifdef SPI_RX_MISO_EN
    .tx_reply(tx_reply), .MISO(MISO), .reply_taken(reply_taken),
`endif
    .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int cyc = 0;
  int last_edge_cyc = 0, vld_rise_cyc = 0, vld_rise_cnt = 0, ferr_cnt = 0, rt_cnt = 0;
  logic vld_q = 1'b0;
  logic [15:0] miso_bits;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vld_q <= rx_valid;
    if (rx_valid && !vld_q) begin
      vld_rise_cyc <= cyc;
      vld_rise_cnt <= vld_rise_cnt + 1;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
`ifdef SPI_RX_MISO_EN
    if (reply_taken) rt_cnt <= rt_cnt + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // nbits data bits MSB first from data[15:], then extra junk edges; optional rx_rdy pulse on completion clk.
  task automatic spi_frame(input logic [15:0] data, input int nbits, input logic pe, input logic w8,
                           input int half, input int extra, input bit rdy_at_done);
    logic b;
    pos_edge = pe;
    width8   = w8;
    SCLK     = ~pe;
    MOSI     = 1'b0;
    SS_n     = 1'b1;
    miso_bits = 16'h0000;
    idle_clks(4);
    SS_n = 1'b0;
    idle_clks(5);
    chk("busy", busy, 1);
    for (int i = 0; i < nbits + extra; i++) begin
      b = 1'b1;
      if (i < nbits) b = data[15-i];
      MOSI = b;
      idle_clks(half);
`ifdef SPI_RX_MISO_EN
      if (i < nbits) miso_bits = {miso_bits[14:0], MISO};
`endif
      SCLK = pe;
      if (i == nbits - 1) last_edge_cyc = cyc;
      if (i == nbits - 1 && rdy_at_done) begin
        idle_clks(3);
        rx_rdy = 1'b1;
        idle_clks(1);
        rx_rdy = 1'b0;
        idle_clks(half - 4);
      end else begin
        idle_clks(half);
      end
      SCLK = ~pe;
    end
    idle_clks(half);
    SS_n = 1'b1;
    idle_clks(8);
  endtask

  int f0, v0;

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; pos_edge = 1'b1; width8 = 1'b0;
    rx_rdy = 1'b1; clr_err = 1'b0;
`ifdef SPI_RX_MISO_EN
    tx_reply = 16'h0000;
`endif
    idle_clks(3);
    rst_n = 1'b1;
    idle_clks(2);
    chk("rst_data", rx_data, 16'h0000);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);

    // 16-bit, rising-edge sampling, minimum legal phase length
    v0 = vld_rise_cnt;
    spi_frame(16'hA5C3, 16, 1'b1, 1'b0, 3, 0, 1'b0);
    chk("t1_data", rx_data, 16'hA5C3);
    chk("t1_pulses", vld_rise_cnt - v0, 1);
    chk("t1_latency", vld_rise_cyc - last_edge_cyc, 4);
    chk("t1_valid_after", rx_valid, 0);
    chk("t1_ovr", overrun, 0);
    chk("t1_ferr", ferr_cnt, 0);

    // 8-bit, falling-edge sampling
    spi_frame(16'h3C00, 8, 1'b0, 1'b1, 4, 0, 1'b0);
    chk("t2_data", rx_data, 16'h003C);

    // back-pressure: overrun, clear, then accept-and-load on the completion clk
    rx_rdy = 1'b0;
    spi_frame(16'h1234, 16, 1'b1, 1'b0, 4, 0, 1'b0);
    chk("t3_valid1", rx_valid, 1);
    chk("t3_data1", rx_data, 16'h1234);
    chk("t3_ovr1", overrun, 0);
    spi_frame(16'h5678, 16, 1'b1, 1'b0, 4, 0, 1'b0);
    chk("t3_data2", rx_data, 16'h1234);
    chk("t3_ovr2", overrun, 1);
    chk("t3_valid2", rx_valid, 1);
    clr_err = 1'b1;
    idle_clks(1);
    clr_err = 1'b0;
    idle_clks(1);
    chk("t3_ovr_clr", overrun, 0);
    spi_frame(16'h9ABC, 16, 1'b1, 1'b0, 4, 0, 1'b1);
    chk("t3_data3", rx_data, 16'h9ABC);
    chk("t3_valid3", rx_valid, 1);
    chk("t3_ovr3", overrun, 0);

    // SS_n raised after 5 sample edges
    f0 = ferr_cnt;
    spi_frame(16'hFFFF, 5, 1'b1, 1'b0, 4, 0, 1'b0);
    chk("t4_ferr_pulse", ferr_cnt - f0, 1);
    chk("t4_valid", rx_valid, 1);
    chk("t4_data", rx_data, 16'h9ABC);
    rx_rdy = 1'b1;
    idle_clks(2);
    chk("t4_consumed", rx_valid, 0);
    spi_frame(16'hFFFF, 16, 1'b1, 1'b0, 4, 0, 1'b0);
    chk("t4_full", rx_data, 16'hFFFF);
    chk("t4_ovr", overrun, 0);

    // surplus edges after a complete word are ignored
    rx_rdy = 1'b0;
    f0 = ferr_cnt;
    v0 = vld_rise_cnt;
    spi_frame(16'h0F0F, 16, 1'b1, 1'b0, 4, 3, 1'b0);
    chk("t5_data", rx_data, 16'h0F0F);
    chk("t5_pulses", vld_rise_cnt - v0, 1);
    chk("t5_ferr", ferr_cnt - f0, 0);
    chk("t5_valid", rx_valid, 1);

    // reset in the middle of a frame
    SS_n = 1'b0;
    idle_clks(5);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1; idle_clks(4); SCLK = 1'b1; idle_clks(4); SCLK = 1'b0;
    end
    idle_clks(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", rx_data, 16'h0000);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_busy", busy, 0);
    SS_n = 1'b1;
    idle_clks(3);
    rst_n = 1'b1;
    rx_rdy = 1'b1;
    idle_clks(4);
    spi_frame(16'h1357, 16, 1'b1, 1'b0, 4, 0, 1'b0);
    chk("post_rst_data", rx_data, 16'h1357);

`ifdef SPI_RX_MISO_EN
    tx_reply = 16'hBEEF;
    f0 = rt_cnt;
    spi_frame(16'h2468, 16, 1'b1, 1'b0, 8, 0, 1'b0);
    chk("miso_stream", miso_bits, 16'hBEEF);
    chk("reply_taken", rt_cnt - f0, 1);
    chk("miso_idle", MISO, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
